// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write port bundle for imem_loader.
// Handshake: a byte moves on a rising clk edge where byte_valid && byte_ready; data is held until then.
interface imem_loader_if;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [2:0]  state;

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error, state
  );

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error, state
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory as
// little-endian words, holding the CPU until the program is complete and verified.
module imem_loader #(
  parameter int          MEM_SIZE = 128,
  parameter logic [31:0] NOP_WORD = 32'h00000013,
  parameter bit          FILL_NOP = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  imem_loader_if.slave bus
);

  localparam int IW = $clog2(MEM_SIZE + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_FILL   = 3'd5,
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } state_e;

  state_e        state_q;
  logic [7:0]    len_lo_q;
  logic [IW-1:0] cnt_q;
  logic [IW-1:0] word_idx_q;
  logic [1:0]    byte_idx_q;
  logic [23:0]   word_q;
  logic [7:0]    csum_q;
  logic          wr_en_q;
  logic [31:0]   wr_addr_q;
  logic [31:0]   wr_data_q;

  logic        byte_ready;
  logic        xfer;
  logic [15:0] len_n;

  assign byte_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                      (state_q == S_DATA)   || (state_q == S_CHECK);
  assign xfer       = bus.byte_valid && byte_ready;
  assign len_n      = {bus.byte_data, len_lo_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      len_lo_q   <= '0;
      cnt_q      <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      csum_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (bus.start) begin
            state_q    <= S_LEN_LO;
            csum_q     <= '0;
            cnt_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len_lo_q <= bus.byte_data;
            csum_q   <= csum_q ^ bus.byte_data;
            state_q  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            csum_q <= csum_q ^ bus.byte_data;
            if (len_n > 16'(MEM_SIZE)) begin
              state_q <= S_ERROR;
            end else begin
              cnt_q      <= IW'(len_n);
              word_idx_q <= '0;
              byte_idx_q <= '0;
              state_q    <= (len_n == 16'd0) ? S_CHECK : S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            csum_q     <= csum_q ^ bus.byte_data;
            byte_idx_q <= byte_idx_q + 2'd1;
            // Bytes shift in from the top so lane 0 ends up in bits 7:0.
            word_q     <= {bus.byte_data, word_q[23:8]};
            if (byte_idx_q == 2'd3) begin
              wr_en_q    <= 1'b1;
              wr_addr_q  <= 32'({word_idx_q, 2'b00});
              wr_data_q  <= {bus.byte_data, word_q};
              word_idx_q <= word_idx_q + IW'(1);
              if ((word_idx_q + IW'(1)) == cnt_q) state_q <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (xfer) begin
            if (bus.byte_data != csum_q)
              state_q <= S_ERROR;
            else if (FILL_NOP && (cnt_q < IW'(MEM_SIZE)))
              state_q <= S_FILL;
            else
              state_q <= S_DONE;
          end
        end
        S_FILL: begin
          // word_idx_q already equals N here; it walks up to MEM_SIZE.
          if (word_idx_q == IW'(MEM_SIZE)) begin
            state_q <= S_DONE;
          end else begin
            wr_en_q    <= 1'b1;
            wr_addr_q  <= 32'({word_idx_q, 2'b00});
            wr_data_q  <= NOP_WORD;
            word_idx_q <= word_idx_q + IW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.byte_ready = byte_ready;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.cpu_hold   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.error      = (state_q == S_ERROR);
  assign bus.state      = state_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the instruction memory. It receives a program as a byte stream over a valid/ready handshake, for example from a UART receiver or a test harness. It assembles little-endian 32-bit instruction words and drives the instruction memory write port at word-aligned byte addresses. It holds the CPU while loading, verifies an XOR checksum, and can optionally back-fill the unused words with NOPs.

Parameters:
MEM_SIZE, 128, instruction memory depth in 32-bit words; a legal word count is 0..MEM_SIZE.
NOP_WORD, 32'h00000013, fill value (addi x0, x0, 0).
FILL_NOP, 1, 1 = after a good load, write NOP_WORD to words count..MEM_SIZE-1; 0 = skip the fill.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  synchronous active-low reset.
start  in  1  begin a load; sampled only in IDLE, DONE or ERROR; ignored otherwise.
byte_valid  in  1  byte_data is valid.
byte_data  in  8  stream byte.
byte_ready  out  1  loader accepts a byte this cycle.
wr_en  out  1  instruction memory write strobe, one cycle per word.
wr_addr  out  32  byte address, always a multiple of 4 (word_index*4).
wr_data  out  32  instruction word.
cpu_hold  out  1  CPU must stall or stay in reset.
done  out  1  load completed successfully (level).
error  out  1  load failed (level).

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE. byte_ready, wr_en, cpu_hold, done and error are 0; wr_addr=0; wr_data=0. Checksum, counters and byte index are cleared.
- Reset mid-load aborts immediately. Words already written stay in memory, and no further writes occur.
- A byte transfer happens on a clk edge with byte_valid && byte_ready. byte_ready is 1 only in LEN_LO, LEN_HI, DATA and CHECK.
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes (each word LSB first), then 1 checksum byte. The checksum equals the XOR of all preceding bytes in the frame, including the length bytes.
- IDLE: start=1 -> LEN_LO. cpu_hold=1 from the next cycle. done, error and the checksum accumulator are cleared.
- LEN_LO: on transfer, latch N[7:0] -> LEN_HI.
- LEN_HI: on transfer, latch N[15:8].
  - N > MEM_SIZE -> ERROR.
  - N == 0 -> CHECK.
  - Otherwise -> DATA with word_index=0 and byte index=0.
- DATA: each transfer places the byte in lane byte_index (bits 8*i+7:8*i).
  - On the 4th byte, wr_en=1 in the next cycle, with wr_addr=word_index*4 and wr_data=the assembled word. word_index then increments.
  - After word N-1 -> CHECK.
  - byte_ready may stay high during the write cycle; back-to-back bytes are legal.
- CHECK: on transfer, compare the byte with the accumulator.
  - Match -> FILL if FILL_NOP=1 and N < MEM_SIZE, else DONE.
  - Mismatch -> ERROR.
- FILL: byte_ready=0. One wr_en per cycle with wr_data=NOP_WORD and wr_addr=k*4, for k=N..MEM_SIZE-1 in ascending order; then DONE.
- DONE: done=1, cpu_hold=0, wr_en=0. Stays until start=1, which behaves as from IDLE.
- ERROR: error=1, cpu_hold=1 (CPU must not run a partial program), byte_ready=0. Stays until start=1.
- wr_en is never asserted outside DATA-write and FILL cycles. At most one write occurs per cycle.
- start while in LEN_LO..FILL is ignored.
- byte_valid with byte_ready=0 is not consumed; no byte is dropped or duplicated.
- Counters are sized for 0..MEM_SIZE with no wrap-around. wr_addr never exceeds (MEM_SIZE-1)*4.

Test Plan:
- Good 2-word load, FILL_NOP=0: bytes 02 00 13 04 40 00 93 04 C0 00 02.
  - Required: wr 0x00->0x00400413, then 0x04->0x00C00493.
  - done=1, error=0, cpu_hold=0; exactly 2 wr_en pulses.
- Same frame with FILL_NOP=1, MEM_SIZE=128: the 2 data writes, then 126 writes of 0x00000013 at 0x08..0x1FC. done follows the last fill write.
- Bad checksum: same frame with last byte 0x03. Required: 2 data writes, error=1, cpu_hold=1, done=0, no fill writes.
- Oversize length: bytes 81 00 (N=129). Required: ERROR right after LEN_HI, zero writes, byte_ready=0 afterwards.
- Handshake stress: random byte_valid gaps, and start pulses mid-DATA. Required: identical writes to the gap-free run, and the start pulses have no effect.
- Reset after the 6th byte of the good frame: all outputs 0 next cycle with state IDLE. A following start plus the full frame loads correctly.
